// File: rtl/example_arbiter_if.sv
// Request/grant bundle between NUM_PORTS requesters and the round-robin arbiter.
// Port 0 is the leftmost (MSB) bit of request and grant.
interface example_arbiter_if #(
  parameter int NUM_PORTS = 3
);
  logic [0:NUM_PORTS-1] request;
  logic [0:NUM_PORTS-1] grant;
  logic                 active;

  modport master (output request, input grant, input active);
  modport slave  (input request, output grant, output active);
endinterface

// File: rtl/example_arbiter.sv
// Round-robin arbiter with registered one-hot grant and per-grant hold timeout.
// Timeout pre-emption is built only when EXAMPLE_TIMEOUT_EN is defined; otherwise a grantee holds until it releases.
module example_arbiter #(
  parameter int NUM_PORTS = 3,
  parameter int TIMEOUT   = 5
) (
  input  logic              clk,
  input  logic              rst,
  example_arbiter_if.slave  bus
);
  localparam int LW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || TIMEOUT < 1) begin : g_param_chk
    $error("example_arbiter: NUM_PORTS must be >= 2 and TIMEOUT >= 1");
  end

  logic [0:NUM_PORTS-1] grant_q, grant_d;
  logic [LW-1:0]        last_q, last_d;
  logic                 keep;
  logic                 found;
  logic [LW-1:0]        idx;

`ifdef EXAMPLE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    grant_d = '0;
    last_d  = last_q;
    found   = 1'b0;
    idx     = '0;
    // grant_q is one-hot, so this is "the grantee still requests"
    keep    = |(grant_q & bus.request);
`ifdef EXAMPLE_TIMEOUT_EN
    cnt_d   = '0;
    keep    = keep && (cnt_q < CW'(TIMEOUT - 1));
`endif
    if (keep) begin
      grant_d = grant_q;
`ifdef EXAMPLE_TIMEOUT_EN
      cnt_d   = cnt_q + CW'(1);
`endif
    end else begin
      // search last+1 .. last (wrapping); last itself is checked last
      for (int k = 1; k <= NUM_PORTS; k++) begin
        idx = LW'((int'(last_q) + k) % NUM_PORTS);
        if (!found && bus.request[idx]) begin
          found        = 1'b1;
          grant_d      = '0;
          grant_d[idx] = 1'b1;
          last_d       = idx;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_q <= '0;
      last_q  <= LW'(NUM_PORTS - 1);
    end else begin
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

`ifdef EXAMPLE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`endif

  assign bus.grant  = grant_q;
  assign bus.active = |grant_q;
endmodule

// File: tb/tb_example_arbiter.sv
// Directed bench for example_arbiter (NUM_PORTS=3, TIMEOUT=5); expectations follow EXAMPLE_TIMEOUT_EN.
module tb_example_arbiter;
  localparam int NP = 3;
  localparam int TO = 5;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  example_arbiter_if #(.NUM_PORTS(NP)) bus ();

  example_arbiter #(.NUM_PORTS(NP), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    bus.request = 3'b000;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic [0:NP-1] exp;
    rst         = 1'b0;
    bus.request = 3'b111;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.grant !== 3'b000 || bus.active !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc %0d: got grant=%b active=%b want grant=000 active=0", i, bus.grant, bus.active);
      end
    end
    rst = 1'b1;
    tick();
    exp = 3'b100;
    checks++;
    if (bus.grant !== exp || bus.active !== 1'b1) begin
      errors++;
      $display("FAIL reset_first_grant: got grant=%b active=%b want grant=%b active=1", bus.grant, bus.active, exp);
    end
    #3 rst = 1'b0;
    #1;
    checks++;
    if (bus.grant !== 3'b000 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got grant=%b active=%b want grant=000 active=0", bus.grant, bus.active);
    end
    bus.request = 3'b000;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_single();
    bus.request = 3'b010;
    for (int i = 0; i < 13; i++) begin
      tick();
      checks++;
      if (bus.grant !== 3'b010 || bus.active !== 1'b1) begin
        errors++;
        $display("FAIL single cyc %0d: got grant=%b active=%b want grant=010 active=1", i, bus.grant, bus.active);
      end
    end
    bus.request = 3'b000;
    tick();
    checks++;
    if (bus.grant !== 3'b000 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got grant=%b active=%b want grant=000 active=0", bus.grant, bus.active);
    end
  endtask

  // entered with last=1 (left by test_single)
  task automatic test_two();
    logic [0:NP-1] exp;
    bus.request = 3'b110;
    for (int i = 0; i < 15; i++) begin
      tick();
`ifdef EXAMPLE_TIMEOUT_EN
      exp = ((i / TO) % 2 == 0) ? 3'b100 : 3'b010;
`else
      exp = 3'b100;
`endif
      checks++;
      if (bus.grant !== exp || bus.active !== 1'b1) begin
        errors++;
        $display("FAIL two cyc %0d: got grant=%b active=%b want grant=%b active=1", i, bus.grant, bus.active, exp);
      end
    end
    bus.request = 3'b000;
    tick();
  endtask

  task automatic test_all();
    logic [0:NP-1] seq [3];
    logic [0:NP-1] exp;
    seq[0] = 3'b100;
    seq[1] = 3'b010;
    seq[2] = 3'b001;
    do_reset();
    bus.request = 3'b111;
    for (int i = 0; i < 18; i++) begin
      tick();
`ifdef EXAMPLE_TIMEOUT_EN
      exp = seq[(i / TO) % 3];
`else
      exp = seq[0];
`endif
      checks++;
      if (bus.grant !== exp || !$onehot(bus.grant)) begin
        errors++;
        $display("FAIL all cyc %0d: got grant=%b want grant=%b", i, bus.grant, exp);
      end
    end
    bus.request = 3'b000;
    tick();
  endtask

  task automatic test_early_release();
    logic [0:NP-1] exp;
    do_reset();
    bus.request = 3'b011;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.grant !== 3'b010) begin
        errors++;
        $display("FAIL early_p1 cyc %0d: got grant=%b want grant=010", i, bus.grant);
      end
    end
    bus.request = 3'b001;
    tick();
    checks++;
    if (bus.grant !== 3'b001) begin
      errors++;
      $display("FAIL early_handover: got grant=%b want grant=001", bus.grant);
    end
    // port 0 joins; port 2 must still see a fresh full hold before losing grant
    bus.request = 3'b101;
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef EXAMPLE_TIMEOUT_EN
      exp = (i < TO - 1) ? 3'b001 : 3'b100;
`else
      exp = 3'b001;
`endif
      checks++;
      if (bus.grant !== exp) begin
        errors++;
        $display("FAIL early_hold cyc %0d: got grant=%b want grant=%b", i, bus.grant, exp);
      end
    end
    bus.request = 3'b000;
    tick();
    checks++;
    if (bus.grant !== 3'b000 || bus.active !== 1'b0) begin
      errors++;
      $display("FAIL early_release_zero: got grant=%b active=%b want grant=000 active=0", bus.grant, bus.active);
    end
  endtask

  task automatic test_no_timeout();
`ifndef EXAMPLE_TIMEOUT_EN
    do_reset();
    bus.request = 3'b111;
    for (int i = 0; i < 25; i++) begin
      tick();
      checks++;
      if (bus.grant !== 3'b100) begin
        errors++;
        $display("FAIL notimeout_hold cyc %0d: got grant=%b want grant=100", i, bus.grant);
      end
    end
    bus.request = 3'b011;
    tick();
    checks++;
    if (bus.grant !== 3'b010) begin
      errors++;
      $display("FAIL notimeout_release: got grant=%b want grant=010", bus.grant);
    end
    bus.request = 3'b000;
    tick();
`endif
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b0;
    bus.request = 3'b000;
    test_reset();
    test_single();
    test_two();
    test_all();
    test_early_release();
    test_no_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
